if_fetch_unit: RTL and testbench

Instruction-fetch stage feeding the IF/ID pipeline register of the RV64 pipelined core. Owns the fetch PC and drives the synchronous instruction BRAM, which has 1-cycle read latency. Buffers returned words in a small FIFO so that decode stalls never drop an instruction. Accepts redirects (branch, jump, JALR) from EX and discards stale in-flight data.

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_fetch_unit_if.sv | 42 ++++
 rtl/if_fifo.sv | 75 +++++++
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Brief    : Shared constants and types for the instruction-fetch stage:
//            NOP encoding, default XLEN/RESET_PC, and fetch FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

  localparam int          DEF_XLEN     = 64;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;

  // addi x0, x0, 0 -- shown to decode whenever no instruction is held
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  // A fetch target must be word aligned; anything in the low two bits is bad
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_if
// Brief    : Bundles the instruction-BRAM port, the EX redirect input and the
//            IF/ID output of the fetch stage. master = fetch unit,
//            slave = surrounding pipeline / memory.
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if
  import if_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int IMEM_AW = 8
);

  // Instruction BRAM (1-cycle read latency)
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;

  // Redirect from EX
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;

  // IF/ID hand-off
  logic               id_stall;
  logic               if_valid;
  logic [31:0]        if_instr;
  logic [XLEN-1:0]    if_pc;

  modport master (
    output imem_en, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_stall
  );

  modport slave (
    input  imem_en, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_stall
  );

endinterface
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_fifo
// Brief    : Synchronous instruction buffer holding {instr, pc} pairs.
//            Supports simultaneous push/pop, a flush that beats both, and a
//            head read straight from the storage entry at the read pointer.
//            DEPTH must be a power of two so the pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module if_fifo #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [31:0]            push_instr,
  input  logic [XLEN-1:0]        push_pc,
  input  logic                   pop,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            head_instr,
  output logic [XLEN-1:0]        head_pc
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              LW         = AW + 1;
  localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle
  assign do_push = push && ((count != FULL_LEVEL) || do_pop);

  // Pointer and occupancy tracking; flush empties the buffer in one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (!do_push && do_pop) count <= count - LW'(1);
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
  assign level      = count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : RV64 instruction-fetch stage. Owns the fetch PC, issues reads to
//            a 1-cycle-latency instruction BRAM under a credit rule that
//            counts the in-flight read, buffers returned words in if_fifo and
//            handles EX redirects by flushing and toggling a fetch epoch so
//            stale responses are discarded.
//            Optional feature macro: IF_MISALIGN_TRAP_EN -- a misaligned
//            redirect halts fetch and raises fetch_misaligned until the next
//            aligned redirect. Without it the low PC bits are simply cleared.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC[XLEN-1:0],
  parameter int              IMEM_AW    = 8,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  if_fetch_unit_if.master             bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic                        fetch_misaligned
`endif
);

  localparam int            LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);

`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            epoch;
  logic            req_epoch;
  logic            inflight;

  logic [LW-1:0]   level;
  logic            fifo_empty;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic            misaligned;
  logic [XLEN-1:0] redirect_target;

  // Buffered words plus the outstanding read must fit; a same-cycle pop
  // deliberately earns no credit so the path stays short.
  assign credit_ok = (level + LW'(inflight)) < DEPTH_LVL;

  // Reset gates the request so the BRAM sees no read while reset is held
  assign issue = reset && (state == FETCH) && !bus.redirect_valid && credit_ok;

  // Responses tagged with an old epoch belong to a squashed stream
  assign push = inflight && (req_epoch == epoch) && !bus.redirect_valid;
  assign pop  = bus.if_valid && !bus.id_stall;

  assign misaligned      = is_misaligned(bus.redirect_pc[1:0]);
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // PC, request tracking and fetch FSM; redirect overrides everything else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      req_pc    <= '0;
      epoch     <= 1'b0;
      req_epoch <= 1'b0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc        <= pc + XLEN'(4);
        req_pc    <= pc;
        req_epoch <= epoch;
      end
      if (bus.redirect_valid) begin
        epoch <= ~epoch;
        pc    <= redirect_target;
        if (TRAP_EN && misaligned) state <= HALT;
        else                       state <= FETCH;
      end
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Sticky trap flag: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_misaligned <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_misaligned <= misaligned;
    end
  end
`endif

  if_fifo #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_instr (bus.imem_rdata),
    .push_pc    (req_pc),
    .pop        (pop),
    .empty      (fifo_empty),
    .level      (level),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  assign bus.imem_en   = issue;
  assign bus.imem_addr = reset ? pc[IMEM_AW+1:2] : '0;
  assign bus.if_valid  = !fifo_empty;
  assign bus.if_instr  = fifo_empty ? NOP_INSTR : head_instr;
  assign bus.if_pc     = fifo_empty ? '0 : head_pc;
  assign fifo_level    = level;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit. A BRAM model returns
//            32'hC0DE_0000 | word_index; accepted instructions are compared
//            against an expected {pc, instr} queue by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int XLEN       = 64;
  localparam int IMEM_AW    = 8;
  localparam int FIFO_DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
`ifdef IF_MISALIGN_TRAP_EN
  logic fetch_misaligned;
`endif

  if_fetch_unit_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW)) bus ();

  if_fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (64'h0),
    .IMEM_AW    (IMEM_AW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fifo_level (fifo_level)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Instruction BRAM model
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [63:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = 32'hC0DE_0000 | {24'h0, p[9:2]};
    exp_q.push_back(e);
  endtask

  // Monitor: every instruction accepted by decode must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.if_valid && !bus.id_stall && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pop: got pc 0x%0h, expected no instruction", bus.if_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", bus.if_pc, e.pc);
        check("pop_instr", 64'(bus.if_instr), 64'(e.instr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let decode accept until every queued expectation is consumed, then stall
  task automatic drain(input string name);
    int n;
    n = 0;
    bus.id_stall = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    bus.id_stall = 1'b1;
    check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic redirect(input logic [63:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_if_valid"},  64'(bus.if_valid),  64'd0);
    check({name, "_if_instr"},  64'(bus.if_instr),  64'h13);
    check({name, "_if_pc"},     bus.if_pc,          64'd0);
    check({name, "_level"},     64'(fifo_level),    64'd0);
    check({name, "_imem_en"},   64'(bus.imem_en),   64'd0);
    check({name, "_imem_addr"}, 64'(bus.imem_addr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    bus.id_stall       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Reset release: requests 0,1,2..., first valid two cycles after first read
    for (int i = 0; i < 8; i++) expect_pc(64'(i * 4));
    reset = 1'b1;
    #1;
    check("t1_en_c0",    64'(bus.imem_en),   64'd1);
    check("t1_addr_c0",  64'(bus.imem_addr), 64'd0);
    check("t1_valid_c0", 64'(bus.if_valid),  64'd0);
    tick();
    check("t1_addr_c1",  64'(bus.imem_addr), 64'd1);
    check("t1_valid_c1", 64'(bus.if_valid),  64'd0);
    tick();
    check("t1_addr_c2",  64'(bus.imem_addr), 64'd2);
    check("t1_valid_c2", 64'(bus.if_valid),  64'd1);
    drain("t1");

    // Decode stall: buffer saturates and reads stop; release pops in order
    repeat (10) tick();
    check("t2_level_sat", 64'(fifo_level),  64'd4);
    check("t2_en_full",   64'(bus.imem_en), 64'd0);
    for (int i = 0; i < 4; i++) expect_pc(64'(32 + i * 4));
    drain("t2");

    // Redirect with three buffered words and one read in flight
    n = 0;
    while (!(fifo_level == 3 && !bus.imem_en) && n < 50) begin
      tick();
      n++;
    end
    check("t3_setup", 64'(n < 50), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h40;
    #1;
    check("t3_no_issue", 64'(bus.imem_en), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("t3_level_flushed", 64'(fifo_level),    64'd0);
    check("t3_valid_flushed", 64'(bus.if_valid),  64'd0);
    check("t3_restart_addr",  64'(bus.imem_addr), 64'd16);
    for (int i = 0; i < 4; i++) expect_pc(64'(64'h40 + i * 4));
    drain("t3");

    // Redirect coinciding with a pop, then a second redirect: last one wins
    check("t4_valid_at_redirect", 64'(bus.if_valid), 64'd1);
    bus.id_stall = 1'b0;
    redirect(64'h40);
    redirect(64'h80);
    check("t4_restart_addr", 64'(bus.imem_addr), 64'h20);
    for (int i = 0; i < 8; i++) expect_pc(64'(64'h80 + i * 4));
    drain("t4");

    // Asynchronous reset mid-stream with two buffered words
    n = 0;
    while (fifo_level != 2 && n < 50) begin
      tick();
      n++;
    end
    check("t5_setup", 64'(n < 50), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    repeat (2) tick();
    for (int i = 0; i < 4; i++) expect_pc(64'(i * 4));
    reset = 1'b1;
    #1;
    check("t5_restart_en",   64'(bus.imem_en),   64'd1);
    check("t5_restart_addr", 64'(bus.imem_addr), 64'd0);
    drain("t5");

    // Misaligned redirect
`ifdef IF_MISALIGN_TRAP_EN
    bus.id_stall = 1'b0;
    redirect(64'h42);
    check("t6_trap_flag", 64'(fetch_misaligned), 64'd1);
    check("t6_trap_en",   64'(bus.imem_en),      64'd0);
    repeat (5) tick();
    check("t6_halt_en",    64'(bus.imem_en),  64'd0);
    check("t6_halt_valid", 64'(bus.if_valid), 64'd0);
    redirect(64'h100);
    check("t6_trap_clear",   64'(fetch_misaligned), 64'd0);
    check("t6_resume_addr",  64'(bus.imem_addr),    64'h40);
    for (int i = 0; i < 4; i++) expect_pc(64'(64'h100 + i * 4));
    drain("t6");
`else
    redirect(64'h42);
    check("t6_aligned_addr", 64'(bus.imem_addr), 64'd16);
    for (int i = 0; i < 4; i++) expect_pc(64'(64'h40 + i * 4));
    drain("t6");
`endif

    // PC wraps modulo 2^64 and the BRAM address wraps at 256 words
    redirect(64'hFFFF_FFFF_FFFF_FFF8);
    check("t7_addr", 64'(bus.imem_addr), 64'hFE);
    expect_pc(64'hFFFF_FFFF_FFFF_FFF8);
    expect_pc(64'hFFFF_FFFF_FFFF_FFFC);
    expect_pc(64'h0);
    expect_pc(64'h4);
    drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
